fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register; drives instrOut/nextPcOut into decodeStage.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, single-outstanding imem requester and IF/ID pipeline register.
// Latency: IF/ID loads one edge after imemDone; a zero-latency memory sustains one instruction per cycle.
// Backpressure: stall freezes IF/ID; a response arriving under stall parks in a one-entry buffer (HOLD).
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter logic [4:0]  HALT_OP   = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic        imemEn,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  input  logic        imemErr,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        validOut,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } stateT;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] nextPc;
    logic        valid;
  } ifIdT;

  stateT       state, stateNxt;
  logic [15:0] pc, pcNxt;
  logic [15:0] bufInstr, bufInstrNxt;
  logic        bufFull, bufFullNxt;
  ifIdT        ifId, ifIdNxt;
  logic        errQ, errNxt;

  logic        reqActive;
  logic        respAvail;
  logic        accept;
  logic [15:0] respInstr;
  logic [15:0] pcPlus2;
  ifIdT        bubble;

  // A request is presented to memory only in FETCH/WAIT; the address is always the PC.
  assign reqActive = (state == FETCH) || (state == WAIT);
  assign imemEn    = reqActive;
  assign imemAddr  = pc;
  assign pcPlus2   = pc + 16'd2;

  // Response source: live memory word in FETCH/WAIT, parked word in HOLD.
  assign respAvail = (reqActive && imemDone) || ((state == HOLD) && bufFull);
  assign respInstr = (state == HOLD) ? bufInstr : imemData;
  assign accept    = respAvail && !stall && !redirect;

  // Bubble keeps the previous nextPc so only instr/valid change.
  always_comb begin
    bubble        = ifId;
    bubble.instr  = NOP_INSTR;
    bubble.valid  = 1'b0;
  end

  // Next-state, PC, buffer, IF/ID and sticky error; redirect overrides everything else.
  always_comb begin
    stateNxt    = state;
    pcNxt       = pc;
    bufInstrNxt = bufInstr;
    bufFullNxt  = bufFull;
    ifIdNxt     = ifId;
    errNxt      = errQ
                | (reqActive && pc[0])
                | (reqActive && imemDone && imemErr && !redirect);

    if (redirect) begin
      pcNxt      = redirectPc;
      bufFullNxt = 1'b0;
      ifIdNxt    = bubble;
      // A request still in flight after this cycle must be drained before reissuing.
      stateNxt   = ((reqActive || (state == DRAIN)) && !imemDone) ? DRAIN : FETCH;
    end else if (accept) begin
      ifIdNxt.instr  = respInstr;
      ifIdNxt.nextPc = pcPlus2;
      ifIdNxt.valid  = 1'b1;
      pcNxt          = pcPlus2;
      bufFullNxt     = 1'b0;
      stateNxt       = (respInstr[15:11] == HALT_OP) ? HALT : FETCH;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (imemDone) begin
            // Decode is stalled: park the word so the address is never re-read.
            bufInstrNxt = imemData;
            bufFullNxt  = 1'b1;
            stateNxt    = HOLD;
          end else begin
            stateNxt = WAIT;
            if (!stall) ifIdNxt = bubble;
          end
        end
        HOLD: begin
          stateNxt = HOLD;
        end
        DRAIN: begin
          if (imemDone) stateNxt = FETCH;
          if (!stall) ifIdNxt = bubble;
        end
        HALT: begin
          if (!stall) ifIdNxt = bubble;
        end
        default: begin
          stateNxt = FETCH;
        end
      endcase
    end
  end

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      bufInstr     <= NOP_INSTR;
      bufFull      <= 1'b0;
      ifId.instr   <= NOP_INSTR;
      ifId.nextPc  <= 16'h0000;
      ifId.valid   <= 1'b0;
      errQ         <= 1'b0;
    end else begin
      state        <= stateNxt;
      pc           <= pcNxt;
      bufInstr     <= bufInstrNxt;
      bufFull      <= bufFullNxt;
      ifId         <= ifIdNxt;
      errQ         <= errNxt;
    end
  end

  assign instrOut  = ifId.instr;
  assign nextPcOut = ifId.nextPc;
  assign validOut  = ifId.valid;
  assign halted    = (state == HALT);
  assign err       = errQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random memory latency/stall/redirect traffic.
// Latency: vectors are applied at negedge and checked 1 time unit after the following posedge.
// Backpressure: random stall and redirect are driven alongside a variable-latency memory model.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        imemEn;
  logic [15:0] imemAddr;
  logic [15:0] imemData;
  logic        imemDone;
  logic        imemErr;
  logic [15:0] instrOut;
  logic [15:0] nextPcOut;
  logic        validOut;
  logic        halted;
  logic        err;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
    .imemEn(imemEn), .imemAddr(imemAddr), .imemData(imemData), .imemDone(imemDone),
    .imemErr(imemErr), .instrOut(instrOut), .nextPcOut(nextPcOut), .validOut(validOut),
    .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        st;
    logic        rd;
    logic [15:0] rpc;
    logic        dn;
    logic [15:0] dat;
    logic        me;
    logic        en;
    logic [15:0] addr;
    logic [15:0] ins;
    logic [15:0] npc;
    logic        vld;
    logic        hlt;
    logic        er;
  } vecT;

  vecT vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic addV(input logic r, input logic st, input logic rd, input logic [15:0] rpc,
                      input logic dn, input logic [15:0] dat, input logic me,
                      input logic en, input logic [15:0] addr, input logic [15:0] ins,
                      input logic [15:0] npc, input logic vld, input logic hlt, input logic er);
    vecT v;
    v.r = r; v.st = st; v.rd = rd; v.rpc = rpc; v.dn = dn; v.dat = dat; v.me = me;
    v.en = en; v.addr = addr; v.ins = ins; v.npc = npc; v.vld = vld; v.hlt = hlt; v.er = er;
    vecs.push_back(v);
  endtask

  // Memory contents for the random phase: unique per address, opcode never HALT.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    logic [15:0] w;
    w     = a * 16'd29 + 16'h03C5;
    w[15] = 1'b1;
    return w;
  endfunction

  initial begin
    logic [15:0] expPc;
    logic        memBusy;
    logic [15:0] memAddr;
    int          memLat;
    int          memCnt;
    int          consumed;
    logic        dnNow;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0;
    imemDone = 1'b0; imemData = 16'h0; imemErr = 1'b0;

    //    r  st rd rpc       dn dat       me | en addr      ins       npc       vld hlt er
    addV(1, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0000, NOP,      16'h0000, 0,  0,  0);
    // zero-latency straight line
    addV(0, 0, 0, 16'h0000, 1, 16'h4100, 0,  1, 16'h0002, 16'h4100, 16'h0002, 1,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h4201, 0,  1, 16'h0004, 16'h4201, 16'h0004, 1,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h4302, 0,  1, 16'h0006, 16'h4302, 16'h0006, 1,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h4403, 0,  1, 16'h0008, 16'h4403, 16'h0008, 1,  0,  0);
    // reset in the middle of a request, with done present
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0008, NOP,      16'h0000, 0,  0,  0);
    addV(1, 0, 0, 16'h0000, 1, 16'h4100, 0,  1, 16'h0000, NOP,      16'h0000, 0,  0,  0);
    // 3-cycle latency
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0000, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0000, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h5A00, 0,  1, 16'h0002, 16'h5A00, 16'h0002, 1,  0,  0);
    // stall while done pulses -> HOLD, then drain buffer without refetch
    addV(0, 1, 0, 16'h0000, 1, 16'h6105, 0,  0, 16'h0002, 16'h5A00, 16'h0002, 1,  0,  0);
    addV(0, 1, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0002, 16'h5A00, 16'h0002, 1,  0,  0);
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0004, 16'h6105, 16'h0004, 1,  0,  0);
    // stall during WAIT keeps IF/ID
    addV(0, 1, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0004, 16'h6105, 16'h0004, 1,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h6206, 0,  1, 16'h0006, 16'h6206, 16'h0006, 1,  0,  0);
    // redirect with request in flight -> DRAIN, returned word discarded
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0006, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 1, 16'h0040, 0, 16'h0000, 0,  0, 16'h0040, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h7777, 0,  1, 16'h0040, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h6307, 0,  1, 16'h0042, 16'h6307, 16'h0042, 1,  0,  0);
    // redirect with same-cycle done squashes it, then HALT at 0010
    addV(0, 0, 1, 16'h0010, 1, 16'h7E7E, 0,  1, 16'h0010, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h0000, 0,  0, 16'h0012, 16'h0000, 16'h0012, 1,  1,  0);
    addV(0, 1, 0, 16'h0000, 1, 16'h6408, 0,  0, 16'h0012, 16'h0000, 16'h0012, 1,  1,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h6408, 0,  0, 16'h0012, NOP,      16'h0000, 0,  1,  0);
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0012, NOP,      16'h0000, 0,  1,  0);
    addV(0, 0, 1, 16'h0020, 0, 16'h0000, 0,  1, 16'h0020, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h6408, 0,  1, 16'h0022, 16'h6408, 16'h0022, 1,  0,  0);
    // redirect to FFFE via DRAIN (second redirect while draining), then wrap
    addV(0, 0, 1, 16'hFFFE, 0, 16'h0000, 0,  0, 16'hFFFE, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 1, 16'hFFFE, 0, 16'h0000, 0,  0, 16'hFFFE, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h7777, 0,  1, 16'hFFFE, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 1, 16'h6509, 0,  1, 16'h0000, 16'h6509, 16'h0000, 1,  0,  0);
    // misaligned pc -> sticky err
    addV(0, 0, 1, 16'h0003, 1, 16'h7E7E, 0,  1, 16'h0003, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0003, NOP,      16'h0000, 0,  0,  1);
    addV(0, 0, 1, 16'h0030, 1, 16'h7E7E, 0,  1, 16'h0030, NOP,      16'h0000, 0,  0,  1);
    addV(0, 0, 0, 16'h0000, 1, 16'h6A0B, 0,  1, 16'h0032, 16'h6A0B, 16'h0032, 1,  0,  1);
    addV(1, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0000, NOP,      16'h0000, 0,  0,  0);
    // imemErr on a delivered word sets err; on a squashed word it does not
    addV(0, 0, 0, 16'h0000, 1, 16'h6C0C, 1,  1, 16'h0002, 16'h6C0C, 16'h0002, 1,  0,  1);
    addV(1, 0, 0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0000, NOP,      16'h0000, 0,  0,  0);
    addV(0, 0, 1, 16'h0008, 1, 16'h6C0C, 1,  1, 16'h0008, NOP,      16'h0000, 0,  0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].r; stall = vecs[i].st; redirect = vecs[i].rd; redirectPc = vecs[i].rpc;
      imemDone = vecs[i].dn; imemData = vecs[i].dat; imemErr = vecs[i].me;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.imemEn", i),   {15'b0, imemEn},   {15'b0, vecs[i].en});
      chk($sformatf("v%0d.imemAddr", i), imemAddr,          vecs[i].addr);
      chk($sformatf("v%0d.instrOut", i), instrOut,          vecs[i].ins);
      if (vecs[i].vld || vecs[i].r)
        chk($sformatf("v%0d.nextPcOut", i), nextPcOut, vecs[i].npc);
      chk($sformatf("v%0d.validOut", i), {15'b0, validOut}, {15'b0, vecs[i].vld});
      chk($sformatf("v%0d.halted", i),   {15'b0, halted},   {15'b0, vecs[i].hlt});
      chk($sformatf("v%0d.err", i),      {15'b0, err},      {15'b0, vecs[i].er});
    end

    // Random phase: expected program-order stream consumed by decode.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imemDone = 1'b0; imemErr = 1'b0;
    @(posedge clk);
    #1;
    expPc    = 16'h0000;
    memBusy  = 1'b0;
    memAddr  = 16'h0000;
    memLat   = 0;
    memCnt   = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (imemEn && !memBusy) begin
        memBusy = 1'b1;
        memAddr = imemAddr;
        memLat  = $urandom_range(0, 3);
        memCnt  = 0;
      end else if (imemEn && memBusy) begin
        chk("rnd.addrStable", imemAddr, memAddr);
      end
      dnNow      = memBusy && (memCnt == memLat);
      rst        = 1'b0;
      imemDone   = dnNow;
      imemData   = dnNow ? memWord(memAddr) : 16'hDEAD;
      stall      = ($urandom_range(0, 3) == 0);
      redirect   = ($urandom_range(0, 19) == 0);
      redirectPc = 16'($urandom_range(0, 127) * 2);
      if (validOut && !stall) begin
        chk("rnd.instr", instrOut, memWord(expPc));
        chk("rnd.nextPc", nextPcOut, expPc + 16'd2);
        expPc = expPc + 16'd2;
        consumed++;
      end
      if (redirect) expPc = redirectPc;
      @(posedge clk);
      #1;
      if (dnNow) memBusy = 1'b0;
      else if (memBusy) memCnt++;
    end
    chk("rnd.progress", {15'b0, (consumed >= 200)}, 16'h0001);
    chk("rnd.halted", {15'b0, halted}, 16'h0000);
    chk("rnd.err", {15'b0, err}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
